cordic_vectoring: RTL and testbench

//  Iterative CORDIC in vectoring mode, the inverse of the rotation datapath: takes a Cartesian vector (x,y) and

---
 rtl/cordic_pkg.sv | 48 ++++
 rtl/cordic_atan.sv | 17 +
 rtl/cordic_vec_step.sv | 47 ++++
 rtl/cordic_vectoring.sv | 161 ++++++++++++++++
 tb/tb_cordic_vectoring.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions for the rotation and vectoring engines.
// Provides the datapath widths, the pi and gain constants, the vectoring FSM
// state type and the arctangent lookup shared by both engines.
package cordic_pkg;

    localparam int DATA_W  = 27;
    localparam int N_ITER  = 20;
    localparam int STAGE_W = 5;

    localparam logic [26:0] PI_Q23       = 27'h1921FB5;
    localparam logic [26:0] CORDIC_K_Q23 = 27'hD2C91A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } vec_state_t;

    // atan(2^-idx) in Q.23 radians, rounded to nearest
    function automatic logic [26:0] atan_q23(input logic [4:0] idx);
        logic [26:0] v;
        case (idx)
            5'd0:    v = 27'h06487ED;
            5'd1:    v = 27'h03B58CE;
            5'd2:    v = 27'h01F5B76;
            5'd3:    v = 27'h00FEADD;
            5'd4:    v = 27'h007FD57;
            5'd5:    v = 27'h003FFAB;
            5'd6:    v = 27'h001FFF5;
            5'd7:    v = 27'h000FFFF;
            5'd8:    v = 27'h0008000;
            5'd9:    v = 27'h0004000;
            5'd10:   v = 27'h0002000;
            5'd11:   v = 27'h0001000;
            5'd12:   v = 27'h0000800;
            5'd13:   v = 27'h0000400;
            5'd14:   v = 27'h0000200;
            5'd15:   v = 27'h0000100;
            5'd16:   v = 27'h0000080;
            5'd17:   v = 27'h0000040;
            5'd18:   v = 27'h0000020;
            5'd19:   v = 27'h0000010;
            default: v = 27'h0000000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_atan.sv
// Arctangent table shared by the CORDIC engines.
// Ports:
//   stage_i    in   STAGE_W   even stage index (0..18)
//   atan_out0  out  DATA_W    atan(2^-stage) in Q.23 radians
//   atan_out1  out  DATA_W    atan(2^-(stage+1)) in Q.23 radians
module cordic_atan
    import cordic_pkg::*;
(
    input  logic [STAGE_W-1:0] stage_i,
    output logic [DATA_W-1:0]  atan_out0,
    output logic [DATA_W-1:0]  atan_out1
);

    assign atan_out0 = atan_q23(stage_i);
    assign atan_out1 = atan_q23(stage_i + STAGE_W'(1));

endmodule

// File: rtl/cordic_vec_step.sv
// One combinational vectoring micro-rotation. Rotates (x,y) toward the +x
// axis by atan(2^-shift) in the direction that reduces |y|, and accumulates
// the consumed angle in z. Both new x and new y use the pre-step values.
// Ports:
//   x_i, y_i, z_i    in   XW      signed current vector and angle
//   shift_i          in   SW      micro-rotation index i
//   atan_i           in   AW      atan(2^-i), Q.23, non-negative
//   x_o, y_o, z_o    out  XW      signed rotated vector and angle
module cordic_vec_step #(
    parameter int XW = 29,
    parameter int AW = 27,
    parameter int SW = 5
) (
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic signed [XW-1:0] z_i,
    input  logic        [SW-1:0] shift_i,
    input  logic        [AW-1:0] atan_i,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic signed [XW-1:0] z_o
);

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;
    logic signed [XW-1:0] atan_ext;

    assign x_sh     = x_i >>> shift_i;
    assign y_sh     = y_i >>> shift_i;
    assign atan_ext = {{(XW-AW){1'b0}}, atan_i};

    always_comb begin
        x_o = x_i;
        y_o = y_i;
        z_o = z_i;
        if (!y_i[XW-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_ext;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_ext;
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: drives y to zero two micro-rotations per
// clock, leaving atan2(y,x) in angle_out and K*|v| (gain not removed) in
// mag_out.
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-high reset
//   start      in   1          request, accepted in IDLE or DONE
//   x_in,y_in  in   DATA_W     signed Q.23 vector, sampled on accepted start
//   busy       out  1          iterations in progress
//   done       out  1          one-cycle pulse when results are valid
//   angle_out  out  DATA_W     signed atan2(y,x), Q.23 radians, (-pi,+pi]
//   mag_out    out  DATA_W+2   unsigned K*sqrt(x^2+y^2)
//
// state | meaning
// IDLE  | waiting for start
// ITER  | two micro-rotations per cycle, stage advances by 2
// DONE  | results latched, done pulse; start here begins a new operation
module cordic_vectoring #(
    parameter int DATA_W = cordic_pkg::DATA_W,
    parameter int N_ITER = cordic_pkg::N_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] angle_out,
    output logic [DATA_W+1:0] mag_out
);

    import cordic_pkg::*;

    localparam int XW = DATA_W + 2;
    localparam int SW = STAGE_W;
    localparam int AW = cordic_pkg::DATA_W;
    localparam logic [SW-1:0] LAST_STAGE = SW'(N_ITER - 2);
    localparam logic signed [XW-1:0] PI_X = XW'(PI_Q23);

    vec_state_t state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic signed [XW-1:0] x_q, x_d;
    logic signed [XW-1:0] y_q, y_d;
    logic signed [XW-1:0] z_q, z_d;
    logic zero_q, zero_d;
    logic [DATA_W-1:0] angle_q, angle_d;
    logic [XW-1:0] mag_q, mag_d;

    logic [AW-1:0] atan0;
    logic [AW-1:0] atan1;
    logic signed [XW-1:0] x1, y1, z1;
    logic signed [XW-1:0] x2, y2, z2;
    logic signed [XW-1:0] x_ext, y_ext;

    assign x_ext = {{2{x_in[DATA_W-1]}}, x_in};
    assign y_ext = {{2{y_in[DATA_W-1]}}, y_in};

    cordic_atan u_atan (
        .stage_i  (stage_q),
        .atan_out0(atan0),
        .atan_out1(atan1)
    );

    cordic_vec_step #(.XW(XW), .AW(AW), .SW(SW)) u_step0 (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .shift_i(stage_q),
        .atan_i (atan0),
        .x_o    (x1),
        .y_o    (y1),
        .z_o    (z1)
    );

    cordic_vec_step #(.XW(XW), .AW(AW), .SW(SW)) u_step1 (
        .x_i    (x1),
        .y_i    (y1),
        .z_i    (z1),
        .shift_i(stage_q + SW'(1)),
        .atan_i (atan1),
        .x_o    (x2),
        .y_o    (y2),
        .z_o    (z2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ITER;
                    stage_d = '0;
                    // With a zero vector y never goes negative, so z would
                    // collect the whole atan sum; remember it and report 0.
                    zero_d  = (x_in == '0) && (y_in == '0);
                    if (!x_in[DATA_W-1]) begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end else begin
                        // Left half-plane: rotate by pi so iteration starts
                        // with x >= 0; y==0 maps to +pi.
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = y_in[DATA_W-1] ? -PI_X : PI_X;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                x_d     = x2;
                y_d     = y2;
                z_d     = z2;
                stage_d = stage_q + SW'(2);
                if (stage_q == LAST_STAGE) begin
                    state_d = DONE;
                    angle_d = zero_q ? '0 : z2[DATA_W-1:0];
                    mag_d   = x2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == ITER);
    assign done      = (state_q == DONE);
    assign angle_out = angle_q;
    assign mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
module tb_cordic_vectoring;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [26:0] x_in;
    logic signed [26:0] y_in;
    logic               busy;
    logic               done;
    logic [26:0]        angle_out;
    logic [28:0]        mag_out;

    int  n_tests = 0;
    int  n_fail  = 0;
    real k_gain;

    always #5 clk = ~clk;

    cordic_vectoring dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_in     (x_in),
        .y_in     (y_in),
        .busy     (busy),
        .done     (done),
        .angle_out(angle_out),
        .mag_out  (mag_out)
    );

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
        n_tests++;
        if (obs - exp > tol || exp - obs > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d", tag, obs, obs, exp, exp, tol);
        end
    endtask

    function automatic longint model_angle(input int x, input int y);
        if (x == 0 && y == 0) return 0;
        return longint'($atan2(real'(y), real'(x)) * 8388608.0);
    endfunction

    function automatic longint model_mag(input int x, input int y);
        return longint'(k_gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
    endfunction

    // Runs one operation on (x,y). inject: extra starts at cycles 3 and 7.
    // from_done: start is raised now, during the previous op's done cycle.
    // chain: return right at the done cycle so the caller can start again.
    task automatic run_op(input string tag, input int x, input int y,
                          input bit inject, input bit from_done, input bit chain);
        int cyc;
        bit seen;
        if (!from_done) begin
            @(posedge clk);
            #1;
        end
        x_in  = 27'(x);
        y_in  = 27'(y);
        start = 1'b1;
        cyc   = 0;
        seen  = 1'b0;
        while (cyc < 40 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (inject && (cyc == 3 || cyc == 7)) begin
                start = 1'b1;
                x_in  = 27'($urandom_range(0, 16777215));
                y_in  = 27'($urandom_range(0, 16777215));
            end
            @(negedge clk);
            if (cyc == 1) chk({tag, "_busy1"}, longint'(busy), 1, 0);
            if (done) seen = 1'b1;
        end
        chk({tag, "_lat"}, cyc, 11, 0);
        chk({tag, "_angle"}, longint'($signed(angle_out)), model_angle(x, y), 64);
        chk({tag, "_mag"}, longint'(mag_out), model_mag(x, y), 128);
        chk({tag, "_busy_at_done"}, longint'(busy), 0, 0);
        if (!chain) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk({tag, "_done_pulse"}, longint'(done), 0, 0);
        end
    endtask

    initial begin
        int rx, ry;
        k_gain = 1.0;
        for (int i = 0; i < 20; i++) k_gain = k_gain * $sqrt(1.0 + $pow(2.0, -2.0 * i));

        rst   = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", longint'(busy), 0, 0);
        chk("rst_done", longint'(done), 0, 0);
        chk("rst_angle", longint'(angle_out), 0, 0);
        chk("rst_mag", longint'(mag_out), 0, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("x_axis", 32'h800000, 0, 1'b0, 1'b0, 1'b0);
        chk("x_axis_mag_k", longint'(mag_out), 64'hD2C91A, 128);
        run_op("diag", 32'h800000, 32'h800000, 1'b0, 1'b0, 1'b0);
        chk("diag_angle_pi4", longint'($signed(angle_out)), 64'h6487ED, 64);
        run_op("pos_y", 0, 32'h800000, 1'b0, 1'b0, 1'b0);
        run_op("neg_y", 0, -32'sh800000, 1'b0, 1'b0, 1'b0);
        run_op("neg_x", -32'sh800000, 0, 1'b0, 1'b0, 1'b0);
        chk("neg_x_plus_pi", longint'($signed(angle_out)), 64'h1921FB5, 64);
        run_op("neg_x_ym1", -32'sh800000, -1, 1'b0, 1'b0, 1'b0);
        chk("neg_x_minus_pi", longint'($signed(angle_out)), -64'sh1921FB5, 64);
        run_op("zero", 0, 0, 1'b0, 1'b0, 1'b0);
        chk("zero_angle_exact", longint'(angle_out), 0, 0);

        run_op("ignore", 32'h300000, -32'sh500000, 1'b1, 1'b0, 1'b0);

        run_op("chain_a", -32'sh123456, 32'h654321, 1'b0, 1'b0, 1'b1);
        chk("chain_done_seen", longint'(done), 1, 0);
        run_op("chain_b", 32'h1000000, -32'sh0ABCDE, 1'b0, 1'b1, 1'b0);

        // reset in the middle of an operation
        @(posedge clk);
        #1;
        x_in  = 27'sh0400000;
        y_in  = 27'sh0200000;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("mid_busy_pre", longint'(busy), 1, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", longint'(busy), 0, 0);
        chk("mid_rst_done", longint'(done), 0, 0);
        chk("mid_rst_angle", longint'(angle_out), 0, 0);
        chk("mid_rst_mag", longint'(mag_out), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", -32'sh0700000, -32'sh0300000, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            do begin
                rx = int'($urandom_range(0, 67108862)) - 33554431;
                ry = int'($urandom_range(0, 67108862)) - 33554431;
            end while (real'(rx) * real'(rx) + real'(ry) * real'(ry) < 70368744177664.0);
            run_op("rand", rx, ry, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
